// File: rtl/hdmi_sched_pkg.sv
// hdmi_sched_pkg: island phase encoding and fixed island period lengths
package hdmi_sched_pkg;
  typedef enum logic [2:0] {
    CTRL        = 3'd0,
    PREAMBLE    = 3'd1,
    LEAD_GUARD  = 3'd2,
    PACKET      = 3'd3,
    TRAIL_GUARD = 3'd4
  } phase_t;
  localparam int PREAMBLE_LEN  = 8;
  localparam int GUARD_LEN     = 2;
  localparam int PACKET_LEN    = 32;
  localparam int VIDEO_RESERVE = 14;
endpackage

// File: rtl/hdmi_rr_arbiter.sv
// hdmi_rr_arbiter: picks a packet owner from req; rotating pointer advances past each winner on take.
// Ports: clk_pixel/reset (async, active-high), req (level requests), take (commit the pick),
// win (chosen index), any (some request present). HDMI_SCHED_FIXED_PRIORITY_EN selects lowest-index-wins.
module hdmi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SW      = $clog2(NUM_REQ)
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic [SW-1:0]      win,
  output logic               any
);
`ifdef HDMI_SCHED_FIXED_PRIORITY_EN
  logic unused;
  assign unused = &{1'b0, clk_pixel, reset, take};
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) begin
        win = SW'(i);
        any = 1'b1;
      end
  end
`else
  logic [SW-1:0] ptr;
  // Scan downward in distance from ptr so the nearest requester at or after ptr wins.
  always_comb begin
    int j;
    j = 0;
    win = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (req[j]) begin
        win = SW'(j);
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_pixel or posedge reset)
    if (reset) ptr <= '0;
    else if (take) ptr <= int'(win) == NUM_REQ - 1 ? '0 : win + 1'b1;
`endif
endmodule

// File: rtl/hdmi_island_scheduler.sv
// hdmi_island_scheduler: sequences one HDMI data island per line and shares its packet slots among requesters.
// Ports: clk_pixel/reset (async, active-high), cx/cy (timing counters), screen_start_x (first active column),
// req (level requests) -> grant (one-cycle at packet pixel 0), packet_sel, packet_null, phase, packet_pixel.
// All outputs describe the cx sampled on the previous edge. HDMI_SCHED_FIXED_PRIORITY_EN: fixed-priority arbitration.
module hdmi_island_scheduler
  import hdmi_sched_pkg::*;
#(
  parameter int BIT_WIDTH     = 10,
  parameter int BIT_HEIGHT    = 10,
  parameter int NUM_REQ       = 4,
  parameter int MAX_PACKETS   = 18,
  parameter int ISLAND_OFFSET = 4
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic [BIT_WIDTH-1:0]       cx,
  input  logic [BIT_HEIGHT-1:0]      cy,
  input  logic [BIT_WIDTH-1:0]       screen_start_x,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] packet_sel,
  output logic                       packet_null,
  output logic [2:0]                 phase,
  output logic [4:0]                 packet_pixel
);
  localparam int SW = $clog2(NUM_REQ);
  phase_t ph, nxt;
  logic [4:0] cnt, slot, n_pk, fit, pc, m1, n_now;
  logic armed, jump, decide, last, slot_start, any;
  logic [BIT_WIDTH-1:0] last_cx;
  logic [BIT_HEIGHT-1:0] last_cy;
  logic signed [BIT_WIDTH:0] avail;
  logic [SW-1:0] win;
  always_comb begin
    avail = $signed({1'b0, screen_start_x}) - (BIT_WIDTH+1)'(ISLAND_OFFSET + PREAMBLE_LEN + 2*GUARD_LEN + VIDEO_RESERVE);
    fit = avail[BIT_WIDTH] ? 5'd0 : 5'(avail[BIT_WIDTH-1:5]);
    pc = 5'($countones(req));
    m1 = pc < fit ? pc : fit;
    n_now = m1 < 5'(MAX_PACKETS) ? m1 : 5'(MAX_PACKETS);
    jump = cx != last_cx + 1'b1 || cy != last_cy;
    decide = ph == CTRL && !armed && cx == BIT_WIDTH'(ISLAND_OFFSET - 1) && n_now != 5'd0;
    last = (ph == PREAMBLE && cnt == 5'(PREAMBLE_LEN - 1)) ||
           ((ph == LEAD_GUARD || ph == TRAIL_GUARD) && cnt == 5'(GUARD_LEN - 1)) ||
           (ph == PACKET && cnt == 5'(PACKET_LEN - 1));
    nxt = ph == PREAMBLE ? LEAD_GUARD :
          ph == LEAD_GUARD ? PACKET :
          ph == PACKET ? (5'(slot + 1'b1) == n_pk ? TRAIL_GUARD : PACKET) : CTRL;
    // A discontinuous cx/cy aborts the island, so a slot never starts on a jump.
    slot_start = !jump && last && nxt == PACKET;
  end
  hdmi_rr_arbiter #(.NUM_REQ(NUM_REQ), .SW(SW)) u_arb (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .req(req),
    .take(slot_start && any),
    .win(win),
    .any(any)
  );
  always_ff @(posedge clk_pixel or posedge reset)
    if (reset) begin
      ph <= CTRL;
      cnt <= '0;
      slot <= '0;
      n_pk <= '0;
      armed <= 1'b0;
      last_cx <= '0;
      last_cy <= '0;
      grant <= '0;
      packet_sel <= '0;
      packet_null <= 1'b0;
    end else begin
      last_cx <= cx;
      last_cy <= cy;
      grant <= '0;
      if ((ph != CTRL || armed) && jump) begin
        ph <= CTRL;
        armed <= 1'b0;
        cnt <= '0;
        packet_null <= 1'b0;
      end else if (decide) begin
        armed <= 1'b1;
        n_pk <= n_now;
      end else if (armed) begin
        armed <= 1'b0;
        ph <= PREAMBLE;
        cnt <= '0;
      end else if (ph != CTRL) begin
        cnt <= last ? 5'd0 : cnt + 1'b1;
        if (last) begin
          ph <= nxt;
          packet_null <= 1'b0;
        end
        if (slot_start) begin
          slot <= ph == LEAD_GUARD ? 5'd0 : slot + 1'b1;
          grant <= any ? NUM_REQ'(1) << win : '0;
          packet_sel <= any ? win : '0;
          packet_null <= !any;
        end
      end
    end
  assign phase = ph;
  assign packet_pixel = ph == PACKET ? cnt : 5'd0;
endmodule
